// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and frame-engine state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 4;

    typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_fifo.sv
// ============================================================================
// Module      : uart_fifo
// Description : Single-clock byte FIFO, 2**AW entries, head visible on dout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo
    import uart_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  uart_byte_t din,
    output uart_byte_t dout,
    output logic [AW:0] level,
    output logic       full,
    output logic       empty
);

    localparam int c_DEPTH = 2**AW;

    uart_byte_t  r_mem [c_DEPTH];
    logic [AW:0] r_wr_count;
    logic [AW:0] r_rd_count;
    logic        w_push;
    logic        w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Counters carry one extra bit so a full FIFO is distinguishable from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_count <= '0;
            r_rd_count <= '0;
        end else begin
            if (w_push) r_wr_count <= r_wr_count + 1'b1;
            if (w_pop)  r_rd_count <= r_rd_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_count[AW-1:0]] <= din;
    end

    assign dout  = r_mem[r_rd_count[AW-1:0]];
    assign level = r_wr_count - r_rd_count;
    assign full  = level[AW];
    assign empty = (level == '0);

endmodule : uart_fifo

`default_nettype wire

// File: rtl/buffered_uarttx.sv
// ============================================================================
// Module      : buffered_uarttx
// Description : FIFO-buffered 8N1 UART transmitter, back-to-back frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module buffered_uarttx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_AW      = 3,
    parameter int STOP_BITS    = 1
) (
    input  logic               clock460800,
    input  logic               resetn,
    input  logic [7:0]         data,
    input  logic               send,
    output logic               ready,
    output logic               busy,
    output logic [FIFO_AW:0]   level,
    output logic               UART_TX
);

    localparam int             c_BW          = $clog2(CLKS_PER_BIT);
    localparam logic [c_BW-1:0] c_BAUD_LAST  = c_BW'(CLKS_PER_BIT - 1);
    localparam logic           c_STOP_LAST   = 1'(STOP_BITS - 1);

    logic [1:0]      r_state;
    logic [c_BW-1:0] r_baud;
    logic [2:0]      r_bit_cnt;
    logic            r_stop_cnt;
    uart_byte_t      r_shift;
    logic            r_tx;

    uart_byte_t      w_head;
    logic [FIFO_AW:0] w_level;
    logic            w_full;
    logic            w_empty;
    logic            w_baud_end;
    logic [c_BW-1:0] w_baud_next;
    logic            w_frame_end;
    logic            w_pop;

    uart_fifo #(
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clock460800),
        .rst_n (resetn),
        .push  (send),
        .pop   (w_pop),
        .din   (data),
        .dout  (w_head),
        .level (w_level),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_baud_end  = (r_baud == c_BAUD_LAST);
    assign w_baud_next = w_baud_end ? '0 : r_baud + 1'b1;
    assign w_frame_end = (r_state == c_ST_STOP) && w_baud_end && (r_stop_cnt == c_STOP_LAST);

    // Pop from IDLE, or straight out of the last stop bit for zero inter-frame gap.
    assign w_pop = !w_empty && ((r_state == c_ST_IDLE) || w_frame_end);

    always_ff @(posedge clock460800 or negedge resetn) begin
        if (!resetn) begin
            r_state    <= c_ST_IDLE;
            r_baud     <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                        r_state <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    r_baud <= w_baud_next;
                    if (w_baud_end) begin
                        r_state   <= c_ST_DATA;
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                    end
                end
                c_ST_DATA: begin
                    r_baud <= w_baud_next;
                    if (w_baud_end) begin
                        if (r_bit_cnt == 3'd7) begin
                            r_state    <= c_ST_STOP;
                            r_stop_cnt <= 1'b0;
                            r_tx       <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end
                c_ST_STOP: begin
                    r_baud <= w_baud_next;
                    if (w_baud_end) begin
                        if (r_stop_cnt == c_STOP_LAST) begin
                            if (w_pop) begin
                                r_shift <= w_head;
                                r_tx    <= 1'b0;
                                r_state <= c_ST_START;
                            end else begin
                                r_state <= c_ST_IDLE;
                            end
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign ready   = !w_full;
    assign busy    = (r_state != c_ST_IDLE) || !w_empty;
    assign level   = w_level;
    assign UART_TX = r_tx;

endmodule : buffered_uarttx

`default_nettype wire

// File: tb/tb_buffered_uarttx.sv
// ============================================================================
// Module      : tb_buffered_uarttx
// Description : Directed self-checking bench for buffered_uarttx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_buffered_uarttx;

    logic       clock460800 = 1'b0;
    logic       resetn      = 1'b0;
    logic [7:0] data        = 8'h00;
    logic       send        = 1'b0;
    logic       ready;
    logic       busy;
    logic [3:0] level;
    logic       UART_TX;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] rx_bytes[$];
    int         rx_starts[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] rx_byte;
    logic [9:0] a5_bits;
    logic       seen_low;
    int         wait_n;

    buffered_uarttx #(
        .CLKS_PER_BIT (4),
        .FIFO_AW      (3),
        .STOP_BITS    (1)
    ) dut (
        .clock460800 (clock460800),
        .resetn      (resetn),
        .data        (data),
        .send        (send),
        .ready       (ready),
        .busy        (busy),
        .level       (level),
        .UART_TX     (UART_TX)
    );

    always #5 clock460800 = ~clock460800;
    always @(posedge clock460800) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock460800);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        data = b;
        send = 1'b1;
        tick();
        send = 1'b0;
        data = 8'hFF;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        check_eq({tag, "_drain"}, {31'd0, busy}, 32'd0);
        repeat (2) tick();
    endtask

    task automatic clear_queues();
        rx_bytes.delete();
        rx_starts.delete();
        exp_bytes.delete();
    endtask

    task automatic check_stream(input string tag, input bit gaps);
        check_eq({tag, "_count"}, rx_bytes.size(), exp_bytes.size());
        foreach (exp_bytes[i]) begin
            if (i < rx_bytes.size())
                check_eq($sformatf("%s_byte%0d", tag, i), {24'd0, rx_bytes[i]}, {24'd0, exp_bytes[i]});
        end
        if (gaps) begin
            for (int i = 1; i < rx_starts.size(); i++)
                check_eq($sformatf("%s_gap%0d", tag, i), rx_starts[i] - rx_starts[i-1], 32'd40);
        end
    endtask

    // Reference receiver: detect start, sample each bit mid-way, require a high stop bit.
    initial begin : rx_model
        forever begin
            @(posedge clock460800);
            #2;
            if (resetn && UART_TX == 1'b0) begin
                rx_starts.push_back(cyc);
                repeat (6) @(posedge clock460800);
                #2;
                rx_byte[0] = UART_TX;
                for (int k = 1; k < 8; k++) begin
                    repeat (4) @(posedge clock460800);
                    #2;
                    rx_byte[k] = UART_TX;
                end
                repeat (4) @(posedge clock460800);
                #2;
                if (UART_TX == 1'b1) rx_bytes.push_back(rx_byte);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        // Reset and idle
        repeat (3) @(posedge clock460800);
        #1;
        resetn = 1'b1;
        repeat (20) tick();
        check_eq("rst_tx",    {31'd0, UART_TX}, 32'd1);
        check_eq("rst_ready", {31'd0, ready},   32'd1);
        check_eq("rst_busy",  {31'd0, busy},    32'd0);
        check_eq("rst_level", {28'd0, level},   32'd0);

        // Single byte 0xA5: fall one edge after the write, then 40-cycle frame
        clear_queues();
        a5_bits = {1'b1, 8'hA5, 1'b0};
        push_byte(8'hA5);
        check_eq("a5_level", {28'd0, level},   32'd1);
        check_eq("a5_pre",   {31'd0, UART_TX}, 32'd1);
        tick();
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("a5_bit%0d", i), {31'd0, UART_TX}, {31'd0, a5_bits[i]});
            if (i < 9) repeat (4) tick();
        end
        repeat (3) tick();
        check_eq("a5_busy_last", {31'd0, busy}, 32'd1);
        tick();
        check_eq("a5_busy_done", {31'd0, busy}, 32'd0);
        exp_bytes.push_back(8'hA5);
        check_stream("a5", 1'b0);

        // Burst of 9 while FSM drains the first: all accepted
        clear_queues();
        for (int i = 0; i < 9; i++) begin
            data = 8'(i);
            send = 1'b1;
            tick();
            if (i == 7) begin
                check_eq("burst_level7", {28'd0, level}, 32'd7);
                check_eq("burst_ready7", {31'd0, ready}, 32'd1);
            end
            exp_bytes.push_back(8'(i));
        end
        send = 1'b0;
        check_eq("burst_level8", {28'd0, level}, 32'd8);
        check_eq("burst_full",   {31'd0, ready}, 32'd0);
        wait_drain("burst");
        check_stream("burst", 1'b1);

        // Burst of 9 with FSM mid-frame: 9th dropped
        clear_queues();
        push_byte(8'h10);
        tick();
        exp_bytes.push_back(8'h10);
        for (int i = 0; i < 9; i++) begin
            data = 8'(i);
            send = 1'b1;
            tick();
            if (i == 7) begin
                check_eq("stall_level8", {28'd0, level}, 32'd8);
                check_eq("stall_ready0", {31'd0, ready}, 32'd0);
            end
            if (i < 8) exp_bytes.push_back(8'(i));
        end
        send = 1'b0;
        check_eq("stall_drop", {28'd0, level}, 32'd8);
        wait_drain("stall");
        check_stream("stall", 1'b1);

        // Loopback of 16 random bytes
        clear_queues();
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            wait_n = 0;
            while (!ready && wait_n < 200) begin
                tick();
                wait_n++;
            end
            push_byte(b);
            exp_bytes.push_back(b);
        end
        wait_drain("loop");
        check_stream("loop", 1'b0);

        // Reset during data bit 3 of 0x3C with two bytes queued
        clear_queues();
        push_byte(8'h3C);
        push_byte(8'h11);
        push_byte(8'h22);
        repeat (16) tick();
        check_eq("mid_level", {28'd0, level},   32'd2);
        check_eq("mid_bit3",  {31'd0, UART_TX}, 32'd1);
        #3;
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_tx",    {31'd0, UART_TX}, 32'd1);
        check_eq("mid_rst_level", {28'd0, level},   32'd0);
        check_eq("mid_rst_ready", {31'd0, ready},   32'd1);
        check_eq("mid_rst_busy",  {31'd0, busy},    32'd0);
        tick();
        resetn = 1'b1;
        repeat (60) tick();
        clear_queues();
        seen_low = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (UART_TX == 1'b0) seen_low = 1'b1;
        end
        check_eq("post_rst_idle",  {31'd0, seen_low}, 32'd0);
        check_eq("post_rst_level", {28'd0, level},    32'd0);
        check_eq("post_rst_busy",  {31'd0, busy},     32'd0);
        check_eq("post_rst_rx",    rx_bytes.size(),   32'd0);

        // Push and pop on the same edge at level 3
        clear_queues();
        push_byte(8'h5A);
        tick();
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        check_eq("sim_pre_level", {28'd0, level}, 32'd3);
        repeat (36) tick();
        check_eq("sim_hold_level", {28'd0, level}, 32'd3);
        push_byte(8'h04);
        check_eq("sim_level", {28'd0, level},   32'd3);
        check_eq("sim_ready", {31'd0, ready},   32'd1);
        check_eq("sim_start", {31'd0, UART_TX}, 32'd0);
        exp_bytes.push_back(8'h5A);
        exp_bytes.push_back(8'h01);
        exp_bytes.push_back(8'h02);
        exp_bytes.push_back(8'h03);
        exp_bytes.push_back(8'h04);
        wait_drain("sim");
        check_stream("sim", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_buffered_uarttx

`default_nettype wire
